array_max_scan: RTL and testbench
=================================

ARRAY_MAX_SCAN -- requirements
Module: array_max_scan

Interface
REQ-001 The module SHALL have parameter BIT_W, default 10, meaning the width of one signed sample.
REQ-002 The module SHALL have parameter LEN, default 16, meaning the number of samples in the flat input array (legal range 1..256).
REQ-003 The module SHALL have derived localparam IDX_W = max(1, clog2(LEN)), the width of the index output.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 arr_in  input  BIT_W*LEN  flat signed sample array; sample n occupies bits [(n+1)*BIT_W-1 : n*BIT_W].
REQ-007 start  input  1  request to scan the current arr_in contents.
REQ-008 busy  output  1  high while a scan is in progress or a result is pending.
REQ-009 max_val  output  BIT_W  signed maximum sample of the captured array.
REQ-010 max_idx  output  IDX_W  index of the sample returned in max_val.
REQ-011 out_valid  output  1  max_val and max_idx are valid.
REQ-012 out_ready  input  1  consumer accepts the result.

Function
REQ-013 The FSM SHALL have three states: IDLE, SCAN, DONE.
REQ-014 In IDLE, start=1 SHALL capture all of arr_in into an internal snapshot register, load max_val=sample0, load max_idx=0, set cnt=1, and go to SCAN; if LEN=1, the FSM SHALL go to DONE instead.
REQ-015 In SCAN, the block SHALL compare one snapshot sample per cycle, sample[cnt], against max_val as signed BIT_W values.
REQ-016 When sample[cnt] > max_val, the block SHALL update max_val and max_idx to that sample and index.
REQ-017 The comparison SHALL be strictly greater-than, so on ties the lowest index wins.
REQ-018 When cnt reaches LEN-1, the block SHALL perform that compare and then go to DONE; otherwise cnt SHALL increment.
REQ-019 Latency: with start sampled at edge N, out_valid SHALL first be high after edge N+LEN-1, i.e. LEN-1 scan cycles.
REQ-020 In DONE, out_valid=1, and max_val and max_idx SHALL stay stable until a cycle with out_ready=1.
REQ-021 In DONE with out_ready=1 and start=0, the FSM SHALL go to IDLE and out_valid SHALL drop on the next edge.
REQ-022 In DONE with out_ready=1 and start=1, the block SHALL capture a new array and enter SCAN directly (back-to-back operation).
REQ-023 start SHALL be ignored in SCAN, and in DONE while out_ready=0.
REQ-024 Changes on arr_in after capture SHALL NOT affect the result in progress.
REQ-025 busy SHALL be 1 in SCAN and DONE, and 0 in IDLE.
REQ-026 max_val and max_idx SHALL retain their last values in IDLE.

Reset
REQ-027 While rst=1, state SHALL be IDLE, and cnt, the snapshot, max_val, max_idx, out_valid and busy SHALL all be 0.
REQ-028 Reset asserted mid-SCAN or in DONE SHALL abort the operation with no result output.
REQ-029 The first start after reset release SHALL operate normally.

Structure
REQ-030 The state encodings (IDLE=0, SCAN=1, DONE=2) and a clog2 constant function SHALL live in the shared package sort_pkg, reused by the sort16 blocks.
REQ-031 The signed greater-than compare-and-select SHALL be a sub-module max_cmp, with inputs a/a_idx and b/b_idx and outputs the winner value and index, ties to a.
REQ-032 Sample selection from the snapshot SHALL be an indexed part-select on cnt; no per-sample unrolled comparator tree.

Verification (BIT_W=10, LEN=16)
REQ-033 Ramp: sample n = n, start one cycle -> out_valid rises 15 cycles after the start edge; max_val=15, max_idx=15.
REQ-034 Signed: sample n = -100-n, except sample7 = -3 -> max_val=-3 (0x3FD), max_idx=7; sample n = -512 for all n -> max_val=-512, max_idx=0.
REQ-035 Tie: samples 3 and 9 = 511, all others 0 -> max_val=511, max_idx=3.
REQ-036 Backpressure: out_ready held 0 for 5 cycles in DONE, with start pulsed meanwhile -> outputs stable and start ignored; out_ready=1 together with start=1 -> new scan begins and busy stays 1.
REQ-037 Reset mid-scan: rst pulsed at scan cycle 8 -> all outputs 0 and state IDLE; a subsequent ramp start produces the REQ-033 result.
REQ-038 Snapshot: arr_in changed to all 0x1FF one cycle after start -> the result still equals the captured ramp (15 at index 15).

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and helpers for the sort/scan block family.
// State encoding and a constant clog2 used for port sizing.
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/max_cmp.sv
// Signed compare-and-select of two tagged samples.
// b wins only when strictly greater, so ties keep a.
module max_cmp #(
  parameter int BIT_W = 10,
  parameter int IDX_W = 4
) (
  input  logic [BIT_W-1:0] a,
  input  logic [IDX_W-1:0] a_idx,
  input  logic [BIT_W-1:0] b,
  input  logic [IDX_W-1:0] b_idx,
  output logic [BIT_W-1:0] win,
  output logic [IDX_W-1:0] win_idx
);

  logic b_gt;

  assign b_gt    = $signed(b) > $signed(a);
  assign win     = b_gt ? b : a;
  assign win_idx = b_gt ? b_idx : a_idx;

endmodule

// File: rtl/array_max_scan.sv
// Sequential signed max/argmax over a captured flat array,
// one sample per cycle, with a valid/ready result handshake.
module array_max_scan
  import sort_pkg::*;
#(
  parameter int BIT_W = 10,
  parameter int LEN   = 16,
  localparam int IDX_W = (clog2(LEN) < 1) ? 1 : clog2(LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_W*LEN-1:0] arr_in,
  input  logic                 start,
  output logic                 busy,
  output logic [BIT_W-1:0]     max_val,
  output logic [IDX_W-1:0]     max_idx,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(LEN - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  state_t                 state;
  state_t                 nxt_state;
  logic [BIT_W*LEN-1:0]   snap;
  logic [IDX_W-1:0]       cnt;
  logic [BIT_W-1:0]       cur;
  logic [BIT_W-1:0]       win;
  logic [IDX_W-1:0]       win_idx;
  logic                   cap;
  logic                   step;
  logic                   last;

  assign cur  = snap[32'(cnt) * BIT_W +: BIT_W];
  assign last = (cnt == LAST);

  max_cmp #(
    .BIT_W (BIT_W),
    .IDX_W (IDX_W)
  ) u_cmp (
    .a       (max_val),
    .a_idx   (max_idx),
    .b       (cur),
    .b_idx   (cnt),
    .win     (win),
    .win_idx (win_idx)
  );

  always_comb begin
    nxt_state = state;
    cap       = 1'b0;
    step      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          cap       = 1'b1;
          nxt_state = (LEN == 1) ? DONE : SCAN;
        end
      end
      SCAN: begin
        step = 1'b1;
        if (last) nxt_state = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (start) begin
            cap       = 1'b1;
            nxt_state = (LEN == 1) ? DONE : SCAN;
          end else begin
            nxt_state = IDLE;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap    <= '0;
      cnt     <= '0;
      max_val <= '0;
      max_idx <= '0;
    end else if (cap) begin
      snap    <= arr_in;
      max_val <= arr_in[BIT_W-1:0];
      max_idx <= '0;
      cnt     <= ONE;
    end else if (step) begin
      max_val <= win;
      max_idx <= win_idx;
      if (!last) cnt <= cnt + ONE;
    end
  end

  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_array_max_scan.sv
// Randomized and directed checks of array_max_scan against
// a simple max/first-index reference model.
module tb_array_max_scan;

  localparam int BW  = 10;
  localparam int LEN = 16;
  localparam int IW  = 4;
  localparam int W   = BW * LEN;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  arr_in;
  logic          start;
  logic          busy;
  logic [BW-1:0] max_val;
  logic [IW-1:0] max_idx;
  logic          out_valid;
  logic          out_ready;

  int vectors     = 0;
  int miscompares = 0;

  array_max_scan #(
    .BIT_W (BW),
    .LEN   (LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arr_in    (arr_in),
    .start     (start),
    .busy      (busy),
    .max_val   (max_val),
    .max_idx   (max_idx),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ref_max(input  logic [W-1:0]  a,
                         output logic [BW-1:0] v,
                         output int            idx);
    int s[LEN];
    int m;
    for (int n = 0; n < LEN; n++)
      s[n] = int'($signed(a[n*BW +: BW]));
    m = s[0];
    foreach (s[n]) if (s[n] > m) m = s[n];
    idx = -1;
    for (int n = LEN - 1; n >= 0; n--)
      if (s[n] == m) idx = n;
    v = BW'(m);
  endtask

  function automatic logic [W-1:0] pack(input int s[LEN]);
    logic [W-1:0] a;
    for (int n = 0; n < LEN; n++) a[n*BW +: BW] = BW'(s[n]);
    return a;
  endfunction

  function automatic logic [W-1:0] ramp();
    int s[LEN];
    for (int n = 0; n < LEN; n++) s[n] = n;
    return pack(s);
  endfunction

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] a);
    logic [BW-1:0] ev;
    int            ei;
    ref_max(a, ev, ei);
    check({tag, ".val"}, 32'(max_val), 32'(ev));
    check({tag, ".idx"}, 32'(max_idx), 32'(ei));
  endtask

  task automatic do_scan(input string tag,
                         input logic [W-1:0] a,
                         input bit chg);
    int n;
    arr_in = a;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".busy"}, 32'(busy), 32'd1);
    if (chg) arr_in = {LEN{10'h1FF}};
    wait_valid(n);
    check({tag, ".lat"}, 32'(n), 32'd15);
    check_result(tag, a);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".drop"}, 32'(out_valid), 32'd0);
    check({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int            s[LEN];
    int            n;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [BW-1:0] hv;
    logic [IW-1:0] hi;

    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    arr_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.busy",  32'(busy),      32'd0);
    check("rst.val",   32'(max_val),   32'd0);
    check("rst.idx",   32'(max_idx),   32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_scan("ramp", ramp(), 1'b0);
    check("ramp.v15", 32'(max_val), 32'h00F);

    for (int k = 0; k < LEN; k++) s[k] = -100 - k;
    s[7] = -3;
    do_scan("signed", pack(s), 1'b0);
    check("signed.raw", 32'(max_val), 32'h3FD);

    for (int k = 0; k < LEN; k++) s[k] = -512;
    do_scan("allmin", pack(s), 1'b0);

    for (int k = 0; k < LEN; k++) s[k] = 0;
    s[3] = 511;
    s[9] = 511;
    do_scan("tie", pack(s), 1'b0);
    check("tie.idx3", 32'(max_idx), 32'd3);

    do_scan("snap", ramp(), 1'b1);

    // Backpressure: hold result, poke start, then chain a new scan.
    for (int k = 0; k < LEN; k++) s[k] = int'($urandom_range(0, 1023));
    a      = pack(s);
    arr_in = a;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid(n);
    check("bp.lat", 32'(n), 32'd15);
    check_result("bp", a);
    hv = max_val;
    hi = max_idx;
    for (int k = 0; k < 5; k++) begin
      start  = (k == 2);
      arr_in = W'({$urandom, $urandom, $urandom, $urandom, $urandom});
      @(posedge clk); #1;
      check("bp.hold_v",  32'(out_valid), 32'd1);
      check("bp.hold_val", 32'(max_val),  32'(hv));
      check("bp.hold_idx", 32'(max_idx),  32'(hi));
    end
    for (int k = 0; k < LEN; k++) s[k] = int'($urandom_range(0, 1023));
    b         = pack(s);
    arr_in    = b;
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    out_ready = 1'b0;
    check("b2b.busy",  32'(busy),      32'd1);
    check("b2b.valid", 32'(out_valid), 32'd0);
    wait_valid(n);
    check("b2b.lat", 32'(n), 32'd15);
    check_result("b2b", b);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b.idle", 32'(busy), 32'd0);

    // Abort mid-scan with reset.
    arr_in = ramp();
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort.valid", 32'(out_valid), 32'd0);
    check("abort.busy",  32'(busy),      32'd0);
    check("abort.val",   32'(max_val),   32'd0);
    check("abort.idx",   32'(max_idx),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort.still", 32'(out_valid), 32'd0);
    do_scan("post_rst", ramp(), 1'b0);
    check("post_rst.v15", 32'(max_val), 32'h00F);

    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < LEN; k++)
        s[k] = (r % 2 == 0) ? int'($urandom_range(0, 1023))
                            : int'($urandom_range(0, 3)) - 2;
      do_scan($sformatf("rnd%0d", r), pack(s), (r % 3 == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
